param_mmio_fifo: RTL and testbench

//  Parametrised successor to the single-register MMIO FIFO used by the AFU.

---
 rtl/param_mmio_fifo.sv | 127 ++++++++++++
 tb/tb_param_mmio_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_mmio_fifo.sv
// param_mmio_fifo
//   WIDTH x DEPTH circular buffer between the AFU MMIO write decode (push) and
//   the MMIO read decode (pop/dout). It keeps an occupancy count, full/empty
//   status and sticky overflow/underflow flags.
//   MODE 0: queue. A true FIFO with a first-word-fall-through head on dout.
//   MODE 1: shift. A fixed-latency delay line. Each push shifts in a word. Once
//           DEPTH words are held, dout shows the word written DEPTH pushes ago.
//
// Handshake: there is no back-pressure. push and pop are single-cycle strobes
//   sampled on the rising clk edge. A push into a full queue is dropped and sets
//   overflow. A pop from an empty queue is ignored and sets underflow. Both
//   flags are sticky until clr_err is asserted.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   push, din       write strobe and write data
//   pop             consume the head entry (MODE 0 only)
//   dout            head/oldest entry, or 0 when no entry is presented
//   full, empty     count == DEPTH, count == 0
//   count           number of valid entries
//   overflow        sticky: a push was dropped because the queue was full
//   underflow       sticky: a pop arrived while the queue was empty
//   clr_err         synchronous clear of both error flags
//   flush           synchronous empty. It overrides push and pop.
module param_mmio_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int MODE  = 0,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err,
  input  logic             flush
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q, unf_q;

  logic             do_push, do_pop, ovf_evt, unf_evt;

  // The pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!flush) begin
      if (MODE == 0) begin
        do_pop  = pop & ~empty;
        // A pop in the same cycle frees the slot, so a push into a full queue is still accepted.
        do_push = push & (~full | do_pop);
        ovf_evt = push & full & ~pop;
        unf_evt = pop & empty;
      end else begin
        // In the delay line, a push into a full buffer retires the oldest word.
        do_push = push;
        do_pop  = push & full;
      end
    end
  end

  always_comb begin
    dout = '0;
    if (MODE == 0) begin
      if (!empty) dout = mem[rd_ptr];
    end else begin
      if (full) dout = mem[rd_ptr];
    end
  end

  // The storage has no reset. Its contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // clr_err is applied first, so an error event in the same cycle still sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~clr_err) | ovf_evt;
      unf_q <= (unf_q & ~clr_err) | unf_evt;
    end
  end

endmodule

// File: tb/tb_param_mmio_fifo.sv
// tb_param_mmio_fifo
//   Directed bench for param_mmio_fifo. It drives three instances from one
//   shared set of inputs: a DEPTH=8 queue, a DEPTH=5 queue and a DEPTH=4 shift
//   line. Each section checks only the instance it targets. The DEPTH=5 section
//   keeps its expected order in a queue model.
module tb_param_mmio_fifo;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         push, pop, clr_err, flush;
  logic [W-1:0] din;

  logic [W-1:0] q8_dout, q5_dout, s4_dout;
  logic [3:0]   q8_count;
  logic [2:0]   q5_count, s4_count;
  logic q8_full, q8_empty, q8_ovf, q8_unf;
  logic q5_full, q5_empty, q5_ovf, q5_unf;
  logic s4_full, s4_empty, s4_ovf, s4_unf;

  param_mmio_fifo #(.WIDTH(W), .DEPTH(8), .MODE(0)) u_q8 (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(q8_dout), .full(q8_full), .empty(q8_empty), .count(q8_count),
    .overflow(q8_ovf), .underflow(q8_unf), .clr_err(clr_err), .flush(flush)
  );

  param_mmio_fifo #(.WIDTH(W), .DEPTH(5), .MODE(0)) u_q5 (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(q5_dout), .full(q5_full), .empty(q5_empty), .count(q5_count),
    .overflow(q5_ovf), .underflow(q5_unf), .clr_err(clr_err), .flush(flush)
  );

  param_mmio_fifo #(.WIDTH(W), .DEPTH(4), .MODE(1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop),
    .dout(s4_dout), .full(s4_full), .empty(s4_empty), .count(s4_count),
    .overflow(s4_ovf), .underflow(s4_unf), .clr_err(clr_err), .flush(flush)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1. Outputs are sampled after step() returns.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; flush = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #2;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; din = W'(first + i);
      step();
    end
    push = 1'b0;
  endtask

  // DEPTH=5 interleaving pattern. There are enough pushes to wrap the pointers.
  localparam logic [12:0] T4_PUSH = 13'b0110111011111; // bit i = cycle i
  localparam logic [12:0] T4_POP  = 13'b1111101111000;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [12:0] pv, qv;
    bit pop_ok, push_ok;
    rst_n = 1'b1;
    idle_inputs();
    #1;

    // ---- reset state ----
    do_reset();
    check("rst_count", 64'(q8_count), 64'd0);
    check("rst_empty", 64'(q8_empty), 64'd1);
    check("rst_full",  64'(q8_full),  64'd0);
    check("rst_dout",  64'(q8_dout),  64'd0);
    check("rst_ovf",   64'(q8_ovf),   64'd0);
    check("rst_unf",   64'(q8_unf),   64'd0);

    // ---- 1: fill DEPTH=8 queue and drain in order ----
    @(posedge clk); #1;
    push_seq(1, 8);
    check("t1_count", 64'(q8_count), 64'd8);
    check("t1_full",  64'(q8_full),  64'd1);
    check("t1_dout",  64'(q8_dout),  64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t1_order", 64'(q8_dout), 64'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("t1_empty", 64'(q8_empty), 64'd1);
    check("t1_dout0", 64'(q8_dout),  64'd0);
    check("t1_unf",   64'(q8_unf),   64'd0);

    // ---- 2: overflow on full, push+pop on full, clr_err ----
    do_reset();
    @(posedge clk); #1;
    push_seq(1, 8);
    push = 1'b1; din = W'(9);
    step();
    push = 1'b0;
    check("t2_ovf",   64'(q8_ovf),   64'd1);
    check("t2_count", 64'(q8_count), 64'd8);
    check("t2_head",  64'(q8_dout),  64'd1);
    push = 1'b1; pop = 1'b1; din = W'(9);
    step();
    push = 1'b0; pop = 1'b0;
    check("t2_pp_dout",  64'(q8_dout),  64'd2);
    check("t2_pp_count", 64'(q8_count), 64'd8);
    check("t2_pp_ovf",   64'(q8_ovf),   64'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t2_clr_ovf", 64'(q8_ovf), 64'd0);
    for (int i = 2; i <= 9; i++) begin
      check("t2_order", 64'(q8_dout), 64'(i));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("t2_empty", 64'(q8_empty), 64'd1);

    // ---- 3: underflow, push+pop while empty, clr_err vs event ----
    do_reset();
    @(posedge clk); #1;
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("t3_unf",   64'(q8_unf),   64'd1);
    check("t3_count", 64'(q8_count), 64'd0);
    push = 1'b1; pop = 1'b1; din = W'(16'h55aa);
    step();
    push = 1'b0; pop = 1'b0;
    check("t3_pp_count", 64'(q8_count), 64'd1);
    check("t3_pp_dout",  64'(q8_dout),  64'h55aa);
    check("t3_pp_unf",   64'(q8_unf),   64'd1);
    pop = 1'b1;
    step();
    check("t3_drain", 64'(q8_empty), 64'd1);
    clr_err = 1'b1;   // pop still asserted while empty, so the event wins
    step();
    pop = 1'b0;
    check("t3_evt_wins", 64'(q8_unf), 64'd1);
    step();
    clr_err = 1'b0;
    check("t3_clr_unf", 64'(q8_unf), 64'd0);

    // ---- 4: DEPTH=5 interleaved, scoreboard order ----
    do_reset();
    exp_q.delete();
    @(posedge clk); #1;
    pv = T4_PUSH;
    qv = T4_POP;
    for (int i = 0; i < 13; i++) begin
      push = pv[i]; pop = qv[i]; din = W'(100 + i);
      pop_ok  = pop && (exp_q.size() > 0);
      push_ok = push && ((exp_q.size() < 5) || pop_ok);
      if (pop_ok) check("t4_head", 64'(q5_dout), 64'(exp_q[0]));
      step();
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(din);
      check("t4_count", 64'(q5_count), 64'(exp_q.size()));
    end
    idle_inputs();
    while (exp_q.size() > 0) begin
      check("t4_drain", 64'(q5_dout), 64'(exp_q.pop_front()));
      pop = 1'b1;
      step();
    end
    pop = 1'b0;
    check("t4_empty", 64'(q5_empty), 64'd1);

    // ---- 5: MODE1 DEPTH=4 delay line ----
    do_reset();
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      push = 1'b1; din = W'(10 * i);
      step();
      check("t5_fill_dout", 64'(s4_dout), 64'd0);
    end
    push = 1'b1; din = W'(40);
    step();
    check("t5_dout4",  64'(s4_dout),  64'd10);
    check("t5_full",   64'(s4_full),  64'd1);
    push = 1'b1; din = W'(50);
    step();
    push = 1'b0;
    check("t5_dout5",  64'(s4_dout),  64'd20);
    check("t5_count5", 64'(s4_count), 64'd4);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("t5_pop_dout",  64'(s4_dout),  64'd20);
    check("t5_pop_count", 64'(s4_count), 64'd4);
    check("t5_ovf", 64'(s4_ovf), 64'd0);
    check("t5_unf", 64'(s4_unf), 64'd0);

    // ---- 6: flush priority, async reset mid-cycle ----
    do_reset();
    @(posedge clk); #1;
    push_seq(1, 3);
    check("t6_pre_count", 64'(q8_count), 64'd3);
    flush = 1'b1; push = 1'b1; din = W'(77);
    step();
    flush = 1'b0; push = 1'b0;
    check("t6_fl_count", 64'(q8_count), 64'd0);
    check("t6_fl_empty", 64'(q8_empty), 64'd1);
    check("t6_fl_dout",  64'(q8_dout),  64'd0);
    push_seq(40, 2);
    check("t6_re_dout", 64'(q8_dout), 64'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ar_count", 64'(q8_count), 64'd0);
    check("t6_ar_empty", 64'(q8_empty), 64'd1);
    check("t6_ar_dout",  64'(q8_dout),  64'd0);
    check("t6_ar_full",  64'(q8_full),  64'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
